// File: rtl/dll_tracker_pkg.sv
// Shared types and widths for the DLL code tracker.
package dll_tracker_pkg;

  localparam int CODE_W = 8;

  // Default timing values. The shared counter must hold the larger of them.
  localparam int UPDATE_INTERVAL_DEF = 1024;
  localparam int LOCK_STABLE_DEF     = 64;
  localparam int CNT_MAX_DEF         = (UPDATE_INTERVAL_DEF > LOCK_STABLE_DEF) ?
                                       UPDATE_INTERVAL_DEF : LOCK_STABLE_DEF;
  localparam int CNT_W               = $clog2(CNT_MAX_DEF + 1);

  typedef enum logic [2:0] {
    OFF,
    PWRUP,
    WAIT_LOCK,
    IDLE,
    PULSE,
    SETTLE,
    CAPTURE
  } state_t;

endpackage

// File: rtl/dll_sync2.sv
// Generic two-flop synchronizer for a single asynchronous level.
module dll_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  // Two back-to-back flops give a metastability-resolved copy of d.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      // stage p0 -> p1
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/dll_code_tracker.sv
// DLL power-up, lock qualification, drift-driven code refresh and
// valid/ack hand-off of stable delay codes to the lane loader.
module dll_code_tracker
  import dll_tracker_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 64,
  parameter int PWRUP_DELAY        = 16,
  parameter int UPDATE_INTERVAL    = 1024,
  parameter int PULSE_WIDTH        = 4,
  parameter int SETTLE_CYCLES      = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              ENABLE,
  input  logic              DLL_LOCK,
  input  logic              DLL_DELAY_DIFF,
  input  logic [CODE_W-1:0] DLL_CODE,
  output logic              DLL_POWERDOWN_N,
  output logic              DLL_CODE_UPDATE,
  output logic [CODE_W-1:0] CODE_OUT,
  output logic              CODE_VALID,
  input  logic              CODE_ACK,
  output logic              LOCKED,
  output logic              LOCK_LOST,
  input  logic              CLEAR_ERR,
  output logic [15:0]       UPDATE_CNT
);

  // Terminal counts: each phase lasts exactly its configured number of cycles.
  localparam logic [CNT_W-1:0] PWRUP_LAST  = CNT_W'(PWRUP_DELAY - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IVL_LAST    = CNT_W'(UPDATE_INTERVAL - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] SETTLE_DONE = CNT_W'(SETTLE_CYCLES);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [CODE_W-1:0]   samp_p0;
  logic                samp_vld_p0;
  logic                first_cap;
  logic                lost_pend;
  logic                off_pend;
  logic [15:0]         upd_cnt;
  logic                lock_s;
  logic                diff_s;
  logic                track_st;
  logic                lock_drop;

  dll_sync2 u_sync_lock (
    .clk   (CLK),
    .rst_n (RESET_N),
    .d     (DLL_LOCK),
    .q     (lock_s)
  );

  dll_sync2 u_sync_diff (
    .clk   (CLK),
    .rst_n (RESET_N),
    .d     (DLL_DELAY_DIFF),
    .q     (diff_s)
  );

  assign track_st   = (state == IDLE) || (state == PULSE) ||
                      (state == SETTLE) || (state == CAPTURE);
  assign lock_drop  = track_st && !lock_s;
  assign UPDATE_CNT = upd_cnt;

  // Control FSM: power sequencing, lock qualification, refresh and hand-off.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state           <= OFF;
      cnt             <= '0;
      samp_p0         <= '0;
      samp_vld_p0     <= 1'b0;
      first_cap       <= 1'b0;
      lost_pend       <= 1'b0;
      off_pend        <= 1'b0;
      upd_cnt         <= '0;
      DLL_POWERDOWN_N <= 1'b0;
      DLL_CODE_UPDATE <= 1'b0;
      CODE_OUT        <= '0;
      CODE_VALID      <= 1'b0;
      LOCKED          <= 1'b0;
      LOCK_LOST       <= 1'b0;
    end else begin
      // A loss event in the same cycle as a clear keeps the flag set.
      if (lock_drop)
        LOCK_LOST <= 1'b1;
      else if (CLEAR_ERR)
        LOCK_LOST <= 1'b0;

      if (state == CAPTURE && CODE_VALID) begin
        // An offered code is always delivered; loss/disable are deferred.
        if (!lock_s) begin
          lost_pend <= 1'b1;
          LOCKED    <= 1'b0;
        end
        if (!ENABLE) begin
          off_pend <= 1'b1;
          LOCKED   <= 1'b0;
        end
        if (CODE_ACK) begin
          CODE_VALID <= 1'b0;
          upd_cnt    <= sat_inc16(upd_cnt);
          lost_pend  <= 1'b0;
          off_pend   <= 1'b0;
          cnt        <= '0;
          if (off_pend || !ENABLE) begin
            state           <= OFF;
            DLL_POWERDOWN_N <= 1'b0;
            LOCKED          <= 1'b0;
          end else if (lost_pend || !lock_s) begin
            state  <= WAIT_LOCK;
            LOCKED <= 1'b0;
          end else begin
            state  <= IDLE;
            LOCKED <= 1'b1;
          end
        end
      end else if (!ENABLE) begin
        state           <= OFF;
        DLL_POWERDOWN_N <= 1'b0;
        DLL_CODE_UPDATE <= 1'b0;
        LOCKED          <= 1'b0;
        cnt             <= '0;
      end else if (lock_drop) begin
        state           <= WAIT_LOCK;
        DLL_CODE_UPDATE <= 1'b0;
        LOCKED          <= 1'b0;
        cnt             <= '0;
      end else begin
        case (state)
          OFF: begin
            state           <= PWRUP;
            DLL_POWERDOWN_N <= 1'b1;
            cnt             <= '0;
          end
          PWRUP: begin
            if (cnt == PWRUP_LAST) begin
              state <= WAIT_LOCK;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WAIT_LOCK: begin
            if (!lock_s) begin
              cnt <= '0;
            end else if (cnt == STABLE_LAST) begin
              // First refresh after qualification ignores the drift flag.
              state           <= PULSE;
              DLL_CODE_UPDATE <= 1'b1;
              first_cap       <= 1'b1;
              cnt             <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          IDLE: begin
            if (cnt == IVL_LAST) begin
              cnt <= '0;
              if (diff_s) begin
                state           <= PULSE;
                DLL_CODE_UPDATE <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PULSE: begin
            if (cnt == PULSE_LAST) begin
              state           <= SETTLE;
              DLL_CODE_UPDATE <= 1'b0;
              samp_vld_p0     <= 1'b0;
              cnt             <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          SETTLE: begin
            if (cnt != SETTLE_DONE) begin
              cnt <= cnt + 1'b1;
            end else begin
              // The code is quasi-static: accept it only once it repeats.
              samp_p0     <= DLL_CODE;
              samp_vld_p0 <= 1'b1;
              if (samp_vld_p0 && (samp_p0 == DLL_CODE))
                state <= CAPTURE;
            end
          end
          CAPTURE: begin
            cnt <= '0;
            if (first_cap || (samp_p0 != CODE_OUT)) begin
              CODE_OUT   <= samp_p0;
              CODE_VALID <= 1'b1;
              first_cap  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
          default: begin
            state <= OFF;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dll_code_tracker.sv
// Directed bench for dll_code_tracker with hand-computed expectations.
module tb_dll_code_tracker;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        ENABLE;
  logic        DLL_LOCK;
  logic        DLL_DELAY_DIFF;
  logic [7:0]  DLL_CODE;
  logic        DLL_POWERDOWN_N;
  logic        DLL_CODE_UPDATE;
  logic [7:0]  CODE_OUT;
  logic        CODE_VALID;
  logic        CODE_ACK;
  logic        LOCKED;
  logic        LOCK_LOST;
  logic        CLEAR_ERR;
  logic [15:0] UPDATE_CNT;

  int checks = 0;
  int errors = 0;

  dll_code_tracker dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .ENABLE          (ENABLE),
    .DLL_LOCK        (DLL_LOCK),
    .DLL_DELAY_DIFF  (DLL_DELAY_DIFF),
    .DLL_CODE        (DLL_CODE),
    .DLL_POWERDOWN_N (DLL_POWERDOWN_N),
    .DLL_CODE_UPDATE (DLL_CODE_UPDATE),
    .CODE_OUT        (CODE_OUT),
    .CODE_VALID      (CODE_VALID),
    .CODE_ACK        (CODE_ACK),
    .LOCKED          (LOCKED),
    .LOCK_LOST       (LOCK_LOST),
    .CLEAR_ERR       (CLEAR_ERR),
    .UPDATE_CNT      (UPDATE_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic cond(input int sel);
    case (sel)
      0:       return DLL_CODE_UPDATE;
      1:       return !DLL_CODE_UPDATE;
      2:       return CODE_VALID;
      3:       return !LOCKED;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int sel, input int budget, output int n);
    n = 0;
    while (!cond(sel) && n < budget) begin
      tick();
      n++;
    end
    if (!cond(sel)) check_val({tag, "_timeout"}, 32'(cond(sel)), 1);
  endtask

  task automatic do_ack();
    CODE_ACK = 1'b1;
    tick();
    CODE_ACK = 1'b0;
  endtask

  initial begin
    int n;
    logic seen;
    RESET_N = 1'b0; ENABLE = 1'b0; DLL_LOCK = 1'b0; DLL_DELAY_DIFF = 1'b0;
    DLL_CODE = 8'h00; CODE_ACK = 1'b0; CLEAR_ERR = 1'b0;
    repeat (3) tick();
    check_val("rst_pdn",   32'(DLL_POWERDOWN_N), 0);
    check_val("rst_upd",   32'(DLL_CODE_UPDATE), 0);
    check_val("rst_valid", 32'(CODE_VALID), 0);
    check_val("rst_cnt",   32'(UPDATE_CNT), 0);
    check_val("rst_lost",  32'(LOCK_LOST), 0);
    RESET_N = 1'b1;
    DLL_LOCK = 1'b1;
    DLL_CODE = 8'h5A;
    repeat (3) tick();
    check_val("off_pdn", 32'(DLL_POWERDOWN_N), 0);

    // Power-up and first forced capture
    ENABLE = 1'b1;
    tick();
    check_val("pdn_rise", 32'(DLL_POWERDOWN_N), 1);
    wait_for("first_pulse", 0, 200, n);
    check_val("first_pulse_lat", n, 80);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("pulse_hi", 32'(DLL_CODE_UPDATE), 1);
    end
    tick();
    check_val("pulse_lo", 32'(DLL_CODE_UPDATE), 0);
    wait_for("first_valid", 2, 50, n);
    check_val("first_valid_lat", n, 11);
    check_val("first_code", 32'(CODE_OUT), 32'h5A);
    check_val("locked_pre_ack", 32'(LOCKED), 0);
    do_ack();
    check_val("ack_valid", 32'(CODE_VALID), 0);
    check_val("ack_locked", 32'(LOCKED), 1);
    check_val("ack_cnt1", 32'(UPDATE_CNT), 1);

    // Drift with changed code
    DLL_DELAY_DIFF = 1'b1;
    DLL_CODE = 8'h5B;
    wait_for("ivl_pulse", 0, 1100, n);
    check_val("ivl_lat", n, 1024);
    wait_for("v5b", 2, 40, n);
    check_val("v5b_lat", n, 15);
    check_val("code_5b", 32'(CODE_OUT), 32'h5B);
    do_ack();
    check_val("cnt2", 32'(UPDATE_CNT), 2);

    // Drift with unchanged code: pulse but no offer
    wait_for("same_pulse", 0, 1100, n);
    check_val("same_lat", n, 1024);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen |= CODE_VALID;
    end
    check_val("same_no_valid", 32'(seen), 0);
    check_val("same_cnt", 32'(UPDATE_CNT), 2);
    check_val("same_locked", 32'(LOCKED), 1);

    // Unstable code: alternate 0x10/0x11, then hold 0x11
    wait_for("alt_pulse", 0, 1100, n);
    wait_for("alt_fall", 1, 10, n);
    check_val("alt_fall_lat", n, 4);
    seen = 1'b0;
    for (int i = 0; i < 22; i++) begin
      DLL_CODE = (i < 20 && (i % 2) == 0) ? 8'h10 : 8'h11;
      tick();
      if (i <= 20) seen |= CODE_VALID;
    end
    check_val("alt_early", 32'(seen), 0);
    check_val("alt_valid", 32'(CODE_VALID), 1);
    check_val("alt_code", 32'(CODE_OUT), 32'h11);
    do_ack();
    check_val("cnt3", 32'(UPDATE_CNT), 3);

    // Lock loss in IDLE
    DLL_DELAY_DIFF = 1'b0;
    DLL_LOCK = 1'b0;
    tick(); tick();
    check_val("loss_sync_lat", 32'(LOCKED), 1);
    tick();
    check_val("loss_locked", 32'(LOCKED), 0);
    check_val("loss_flag", 32'(LOCK_LOST), 1);
    check_val("loss_upd", 32'(DLL_CODE_UPDATE), 0);
    CLEAR_ERR = 1'b1;
    tick();
    CLEAR_ERR = 1'b0;
    check_val("clear_err", 32'(LOCK_LOST), 0);

    // Short lock glitch restarts qualification
    seen = 1'b0;
    DLL_LOCK = 1'b1;
    for (int i = 0; i < 30; i++) begin tick(); seen |= DLL_CODE_UPDATE; end
    DLL_LOCK = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); seen |= DLL_CODE_UPDATE; end
    check_val("glitch_no_pulse", 32'(seen), 0);
    DLL_LOCK = 1'b1;
    wait_for("requal", 0, 100, n);
    check_val("requal_lat", n, 66);
    wait_for("requal_v", 2, 40, n);
    check_val("requal_v_lat", n, 15);
    check_val("requal_code", 32'(CODE_OUT), 32'h11);
    do_ack();
    check_val("cnt4", 32'(UPDATE_CNT), 4);
    check_val("relocked", 32'(LOCKED), 1);

    // Loss coincident with CLEAR_ERR: set wins
    CLEAR_ERR = 1'b1;
    DLL_LOCK = 1'b0;
    wait_for("coinc", 3, 10, n);
    check_val("coinc_lat", n, 3);
    check_val("coinc_set_wins", 32'(LOCK_LOST), 1);
    tick();
    check_val("coinc_then_clear", 32'(LOCK_LOST), 0);
    CLEAR_ERR = 1'b0;

    // Held-off ack while lock drops and ENABLE falls
    DLL_LOCK = 1'b1;
    wait_for("hold_v", 2, 200, n);
    check_val("hold_v_lat", n, 81);
    check_val("hold_code", 32'(CODE_OUT), 32'h11);
    DLL_LOCK = 1'b0;
    ENABLE = 1'b0;
    DLL_CODE = 8'h77;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (CODE_VALID !== 1'b1 || CODE_OUT !== 8'h11) seen = 1'b1;
    end
    check_val("hold_stable", 32'(seen), 0);
    check_val("hold_lost", 32'(LOCK_LOST), 1);
    check_val("hold_locked", 32'(LOCKED), 0);
    check_val("hold_pdn", 32'(DLL_POWERDOWN_N), 1);
    do_ack();
    check_val("hold_ack_valid", 32'(CODE_VALID), 0);
    check_val("hold_ack_pdn", 32'(DLL_POWERDOWN_N), 0);
    check_val("cnt5", 32'(UPDATE_CNT), 5);
    check_val("hold_ack_locked", 32'(LOCKED), 0);
    tick();
    check_val("off_stays", 32'(DLL_POWERDOWN_N), 0);

    // Asynchronous reset during PULSE
    DLL_LOCK = 1'b1;
    CLEAR_ERR = 1'b1;
    tick();
    CLEAR_ERR = 1'b0;
    check_val("clr_in_off", 32'(LOCK_LOST), 0);
    ENABLE = 1'b1;
    wait_for("rp_pulse", 0, 200, n);
    check_val("rp_lat", n, 81);
    tick();
    RESET_N = 1'b0;
    #1;
    check_val("arst_upd", 32'(DLL_CODE_UPDATE), 0);
    check_val("arst_pdn", 32'(DLL_POWERDOWN_N), 0);
    check_val("arst_cnt", 32'(UPDATE_CNT), 0);
    check_val("arst_code", 32'(CODE_OUT), 0);
    tick();
    RESET_N = 1'b1;

    // Counter saturation
    wait_for("sat_v", 2, 300, n);
    check_val("sat_code", 32'(CODE_OUT), 32'h77);
    force dut.upd_cnt = 16'hFFFE;
    #1;
    release dut.upd_cnt;
    do_ack();
    check_val("sat_ffff", 32'(UPDATE_CNT), 32'hFFFF);
    DLL_DELAY_DIFF = 1'b1;
    DLL_CODE = 8'h22;
    wait_for("sat_v2", 2, 1200, n);
    check_val("sat_code2", 32'(CODE_OUT), 32'h22);
    do_ack();
    check_val("sat_hold", 32'(UPDATE_CNT), 32'hFFFF);
    check_val("sat_locked", 32'(LOCKED), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
